// File: rtl/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
//
// Cycle-accurate data-memory model for CPU-level benches. It has
// byte-addressable little-endian storage, a configurable access latency and
// all RV32I load/store widths. Misaligned accesses are flagged on a sticky
// error output.
//
// Parameters
//   ADDR_WIDTH : byte-address bits used. Depth is 2^ADDR_WIDTH bytes, and the
//                upper address bits are ignored so addresses wrap.
//   LATENCY    : BUSYWAIT cycles per access (1..255).
//
// Ports
//   CLK        in   clock; all state changes on the rising edge
//   RESET_N    in   asynchronous active-low reset (clears memory too)
//   READ       in   [3] load request, [2:0] funct3
//   WRITE      in   [2] store request, [1:0] size (00 SB, 01 SH, 10 SW)
//   ADDRESS    in   byte address
//   WRITE_DATA in   store data (low byte/half/word used)
//   READ_DATA  out  registered load result, held until the next load completes
//   BUSYWAIT   out  high while an accepted access is in progress
//   MISALIGN   out  sticky misalignment flag, cleared only by reset
// ----------------------------------------------------------------------------
module tb_data_memory #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  READ,
    input  logic [2:0]  WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The first busy cycle is the IDLE acceptance cycle, so BUSY runs for
    // LATENCY-1 cycles: counter values LATENCY-2 down to 0.
    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] sz,
                                           input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (is_store) begin
            case (sz)
                2'b01:   m = a[0];
                2'b10:   m = (a != 2'b00);
                default: m = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b001, 3'b101: m = a[0];
                3'b010:         m = (a != 2'b00);
                default:        m = 1'b0;
            endcase
        end
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [31:0] raw);
        logic [31:0] v;
        v = 32'h0000_0000;
        case (f3)
            3'b000:  v = {{24{raw[7]}}, raw[7:0]};
            3'b001:  v = {{16{raw[15]}}, raw[15:0]};
            3'b010:  v = raw;
            3'b100:  v = {24'h00_0000, raw[7:0]};
            3'b101:  v = {16'h0000, raw[15:0]};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] sz);
        logic [3:0] m;
        m = 4'b0000;
        case (sz)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    store_q, store_d;
    logic [2:0]              f3_q, f3_d;
    logic [1:0]              sz_q, sz_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    mis_q, mis_d;

    // Operands of the access that completes this cycle
    logic                    req_s;
    logic                    busy_s;
    logic                    fire_s;
    logic                    acc_store_s;
    logic [2:0]              acc_f3_s;
    logic [1:0]              acc_sz_s;
    logic [ADDR_WIDTH-1:0]   acc_addr_s;
    logic [31:0]             acc_wdata_s;
    logic                    acc_mis_s;
    logic [ADDR_WIDTH-1:0]   idx_s [4];
    logic [31:0]             raw_s;
    logic [3:0]              we_s;
    logic [7:0]              mem_s [DEPTH];
    logic                    unused_addr_s;

    assign req_s         = READ[3] | WRITE[2];
    assign unused_addr_s = ^ADDRESS[31:ADDR_WIDTH];

    // Next-state logic; with LATENCY 1 the access completes at the accepting
    // edge, so the live inputs are the access operands in that case.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        f3_d        = f3_q;
        sz_d        = sz_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_s      = 1'b0;
        fire_s      = 1'b0;
        acc_store_s = store_q;
        acc_f3_s    = f3_q;
        acc_sz_s    = sz_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    busy_s      = 1'b1;
                    // A store wins when both requests are raised.
                    store_d     = WRITE[2];
                    f3_d        = READ[2:0];
                    sz_d        = WRITE[1:0];
                    addr_d      = ADDRESS[ADDR_WIDTH-1:0];
                    wdata_d     = WRITE_DATA;
                    acc_store_s = WRITE[2];
                    acc_f3_s    = READ[2:0];
                    acc_sz_s    = WRITE[1:0];
                    acc_addr_s  = ADDRESS[ADDR_WIDTH-1:0];
                    acc_wdata_s = WRITE_DATA;
                    if (LATENCY == 1) begin
                        fire_s  = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy_s = 1'b1;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    fire_s  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // A request still held here is only sampled again in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access datapath: byte lanes, load result, store enables, error flag.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx_s[k] = acc_addr_s + ADDR_WIDTH'(k);
        end
        acc_mis_s = is_misaligned(acc_store_s, acc_f3_s, acc_sz_s, acc_addr_s[1:0]);
        raw_s     = {mem_s[idx_s[3]], mem_s[idx_s[2]], mem_s[idx_s[1]], mem_s[idx_s[0]]};
        we_s      = 4'b0000;
        rdata_d   = rdata_q;
        mis_d     = mis_q;
        if (fire_s) begin
            if (acc_mis_s) begin
                mis_d = 1'b1;
            end else begin
                mis_d = mis_q;
            end
            if (acc_store_s) begin
                we_s = acc_mis_s ? 4'b0000 : store_mask(acc_sz_s);
            end else begin
                rdata_d = acc_mis_s ? 32'h0000_0000 : load_extend(acc_f3_s, raw_s);
            end
        end else begin
            we_s = 4'b0000;
        end
    end

    // Control and result registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            sz_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            sz_q    <= sz_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // One register per byte so the whole array clears on reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(g);
        logic       hit_s;
        logic [7:0] wbyte_s;
        logic [7:0] byte_q;

        // Select the store lane, if any, that targets this byte.
        always_comb begin
            hit_s   = 1'b0;
            wbyte_s = 8'h00;
            for (int k = 0; k < 4; k++) begin
                if (we_s[k] && (idx_s[k] == IDX)) begin
                    hit_s   = 1'b1;
                    wbyte_s = acc_wdata_s[8*k +: 8];
                end else begin
                    hit_s   = hit_s;
                end
            end
        end

        // Storage byte.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                byte_q <= 8'h00;
            end else if (hit_s) begin
                byte_q <= wbyte_s;
            end else begin
                byte_q <= byte_q;
            end
        end

        assign mem_s[g] = byte_q;
    end

    // BUSYWAIT must rise in the same cycle a request appears, so it is
    // combinational; it is forced low while reset is held.
    assign BUSYWAIT  = busy_s & RESET_N;
    assign READ_DATA = rdata_q;
    assign MISALIGN  = mis_q;

endmodule
